// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: opcodes, size codes, FSM states and opcode helpers for the MEM-stage load/store unit.
package mem_access_unit_pkg;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DISCARD} state_t;
  function automatic logic is_load(input logic [5:0] op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
  endfunction
  function automatic logic is_store(input logic [5:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction
  function automatic logic [1:0] op_size(input logic [5:0] op);
    return (op == OP_LW || op == OP_SW) ? SIZE_W :
           (op == OP_LH || op == OP_LHU || op == OP_SH) ? SIZE_H : SIZE_B;
  endfunction
  // low address bits that must be zero for a naturally aligned access
  function automatic logic [1:0] align_bits(input logic [5:0] op);
    return op_size(op) == SIZE_W ? 2'b11 : op_size(op) == SIZE_H ? 2'b01 : 2'b00;
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: store lane replication and strobes, plus load byte/half extraction with sign/zero extension.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] wdata_lane,
  output logic [3:0]  wstrb,
  output logic [1:0]  size,
  output logic [31:0] rdata_ext
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = 8'(rword >> {addr, 3'b000});
    h = addr[1] ? rword[31:16] : rword[15:0];
    size = op_size(op);
    wdata_lane = op == OP_SB ? {4{wdata[7:0]}} : op == OP_SH ? {2{wdata[15:0]}} : op == OP_SW ? wdata : '0;
    wstrb = op == OP_SB ? 4'b0001 << addr : op == OP_SH ? 4'b0011 << {addr[1], 1'b0} : op == OP_SW ? 4'b1111 : 4'b0000;
    rdata_ext = op == OP_LB  ? {{24{b[7]}}, b} :
                op == OP_LBU ? {24'b0, b} :
                op == OP_LH  ? {{16{h[15]}}, h} :
                op == OP_LHU ? {16'b0, h} : rword;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine with SRAM-like request/response handshake and pipeline stall.
// Define MEM_ADDR_EXC_EN to raise adel_o/ades_o on misaligned accesses instead of silently aligning them.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [5:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic [ADDR_W-1:0] bad_addr_o,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);
  state_t state, next, after_accept;
  logic [5:0] req_op;
  logic [ADDR_W-1:0] req_addr, eff_addr;
  logic [DATA_W-1:0] req_wdata, load_ext;
  logic mem_op, misaligned, start, resp;

  assert property (@(posedge clk) DATA_W == 32);

  assign mem_op = en_i && (is_load(op_i) || is_store(op_i));
`ifdef MEM_ADDR_EXC_EN
  assign misaligned = |(addr_i[1:0] & align_bits(op_i));
  assign adel_o = mem_op && is_load(op_i) && misaligned;
  assign ades_o = mem_op && is_store(op_i) && misaligned;
  assign bad_addr_o = (adel_o || ades_o) ? addr_i : '0;
  assign eff_addr = addr_i;
`else
  assign misaligned = 1'b0;
  assign adel_o = 1'b0;
  assign ades_o = 1'b0;
  assign bad_addr_o = '0;
  assign eff_addr = {addr_i[ADDR_W-1:2], addr_i[1:0] & ~align_bits(op_i)};
`endif
  assign start = mem_op && !flush_i && !misaligned;
  // gated by rst so the hold drops in the same cycle an asynchronous reset arrives
  assign stall_o = !rst && ((state == S_IDLE && start) || state == S_REQ || state == S_WAIT ||
                            (state == S_DISCARD && mem_op));
  assign data_req = state == S_REQ;
  assign data_wr = is_store(req_op);
  assign data_addr = req_addr;
  assign rdata_valid_o = state == S_DONE && is_load(req_op);
  assign resp = data_data_ok && (state == S_WAIT || (state == S_REQ && data_addr_ok));

  mem_lane_align u_align (
    .op        (req_op),
    .addr      (req_addr[1:0]),
    .wdata     (req_wdata),
    .rword     (data_rdata),
    .wdata_lane(data_wdata),
    .wstrb     (data_wstrb),
    .size      (data_size),
    .rdata_ext (load_ext)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= next;

  // once the port has accepted a request its response must still be drained on a flush
  always_comb begin
    after_accept = flush_i ? (data_data_ok ? S_IDLE : S_DISCARD) : (data_data_ok ? S_DONE : S_WAIT);
    next = state;
    case (state)
      S_IDLE:    next = start ? S_REQ : S_IDLE;
      S_REQ:     next = data_addr_ok ? after_accept : (flush_i ? S_IDLE : S_REQ);
      S_WAIT:    next = after_accept;
      S_DONE:    next = S_IDLE;
      S_DISCARD: next = data_data_ok ? S_IDLE : S_DISCARD;
      default:   next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      req_op <= '0;
      req_addr <= '0;
      req_wdata <= '0;
    end else if (state == S_IDLE && start) begin
      req_op <= op_i;
      req_addr <= eff_addr;
      req_wdata <= wdata_i;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) rdata_o <= '0;
    else if (resp && !flush_i && is_load(req_op)) rdata_o <= load_ext;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of mem_access_unit against a byte-lane reference model.
module tb_mem_access_unit;
  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
  localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2b;

  logic clk = 1'b0;
  logic rst, en_i, flush_i, data_addr_ok, data_data_ok;
  logic [5:0] op_i;
  logic [31:0] addr_i, wdata_i, data_rdata;
  logic stall_o, rdata_valid_o, adel_o, ades_o, data_req, data_wr;
  logic [31:0] rdata_o, bad_addr_o, data_addr, data_wdata;
  logic [1:0] data_size;
  logic [3:0] data_wstrb;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] last_load = '0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .en_i(en_i), .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .flush_i(flush_i), .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .adel_o(adel_o), .ades_o(ades_o), .bad_addr_o(bad_addr_o), .data_req(data_req),
    .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata)
  );

  function automatic int nbytes(input logic [5:0] op);
    return (op == LB || op == LBU || op == SB) ? 1 : (op == LH || op == LHU || op == SH) ? 2 : 4;
  endfunction

  function automatic bit is_st(input logic [5:0] op);
    return op == SB || op == SH || op == SW;
  endfunction

  // {strobes, lane data}: lane i carries register byte (i mod n); strobed when inside the access window
  function automatic logic [35:0] exp_store(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd);
    int n = nbytes(op);
    int off = int'(addr[1:0]) - int'(addr[1:0]) % n;
    logic [35:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = wd[8*(i % n) +: 8];
      r[32+i] = (i >= off) && (i < off + n);
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rword);
    int n = nbytes(op);
    int off = int'(addr[1:0]) - int'(addr[1:0]) % n;
    longint unsigned span = 64'd1 << (8 * n);
    longint unsigned v = (64'(rword) >> (8 * off)) % span;
    if ((op == LB || op == LH) && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  // drives one memory instruction and plays the data port with alat/dlat cycle latencies
  task automatic xact(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rword,
                      input int alat, input int dlat, output int stalls, output int valids,
                      output logic [31:0] q_addr, output logic [31:0] q_wdata, output logic [31:0] q_rdata,
                      output logic [3:0] q_strb, output logic [1:0] q_size, output logic q_wr, output bit done);
    int reqc = 0, waitc = 0;
    bit acc = 0, resp = 0, fin;
    stalls = 0; valids = 0; done = 0;
    q_addr = 'x; q_wdata = 'x; q_rdata = 'x; q_strb = 'x; q_size = 'x; q_wr = 1'bx;
    @(negedge clk);
    en_i = 1; op_i = op; addr_i = addr; wdata_i = wd; flush_i = 0;
    for (int c = 0; c < 50 && !done; c++) begin
      fin = resp;
      data_addr_ok = 0; data_data_ok = 0; data_rdata = $urandom;
      if (data_req) begin
        if (reqc == 0) begin
          q_addr = data_addr; q_wdata = data_wdata; q_strb = data_wstrb; q_size = data_size; q_wr = data_wr;
        end
        if (reqc == alat) begin
          data_addr_ok = 1; acc = 1;
          if (dlat == 0) begin data_data_ok = 1; data_rdata = rword; resp = 1; end
        end
        reqc++;
      end else if (acc && !resp) begin
        waitc++;
        if (waitc == dlat) begin data_data_ok = 1; data_rdata = rword; resp = 1; end
      end
      #1;
      if (stall_o) stalls++;
      if (rdata_valid_o) begin valids++; q_rdata = rdata_o; end
      if (fin && !stall_o) done = 1;
      @(negedge clk);
    end
    en_i = 0; data_addr_ok = 0; data_data_ok = 0;
    #1;
    if (stall_o) stalls++;
    if (rdata_valid_o) valids++;
  endtask

  task automatic test_reset();
    rst = 1; en_i = 0; op_i = 0; addr_i = 0; wdata_i = 0; flush_i = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({stall_o, rdata_valid_o, adel_o, ades_o, data_req, data_wr} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 000000", {stall_o, rdata_valid_o, adel_o, ades_o, data_req, data_wr});
    end
    n_cmp++;
    if ({rdata_o, bad_addr_o, data_addr, data_wdata, data_wstrb, data_size} !== '0) begin
      n_bad++; $display("FAIL reset_data: rdata=%h bad=%h addr=%h wdata=%h strb=%b size=%0d want all 0",
                        rdata_o, bad_addr_o, data_addr, data_wdata, data_wstrb, data_size);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_store_byte();
    int st, va; logic [31:0] qa, qw, qr; logic [3:0] qs; logic [1:0] qz; logic qwr; bit ok;
    xact(SB, 32'h1003, 32'h000000A5, 32'h0, 0, 1, st, va, qa, qw, qr, qs, qz, qwr, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL sb_done: transfer did not complete"); end
    n_cmp++; if (qw !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL sb_wdata: got %h want a5a5a5a5", qw); end
    n_cmp++; if (qs !== 4'b1000) begin n_bad++; $display("FAIL sb_wstrb: got %b want 1000", qs); end
    n_cmp++; if (qz !== 2'd0 || qwr !== 1'b1) begin n_bad++; $display("FAIL sb_size_wr: got size=%0d wr=%b want 0 1", qz, qwr); end
    n_cmp++; if (st !== 3) begin n_bad++; $display("FAIL sb_stall: got %0d cycles want 3", st); end
    n_cmp++; if (va !== 0) begin n_bad++; $display("FAIL sb_valid: got %0d pulses want 0", va); end
  endtask

  task automatic test_load_byte();
    int st, va; logic [31:0] qa, qw, qr; logic [3:0] qs; logic [1:0] qz; logic qwr; bit ok;
    xact(LB, 32'h2001, 32'h0, 32'h1234F600, 0, 0, st, va, qa, qw, qr, qs, qz, qwr, ok);
    last_load = 32'hFFFFFFF6;
    n_cmp++; if (!ok || st !== 2) begin n_bad++; $display("FAIL lb_timing: done=%b stall=%0d want 1 2", ok, st); end
    n_cmp++; if (va !== 1) begin n_bad++; $display("FAIL lb_valid: got %0d pulses want 1", va); end
    n_cmp++; if (qr !== 32'hFFFFFFF6) begin n_bad++; $display("FAIL lb_rdata: got %h want fffffff6", qr); end
    n_cmp++; if (qs !== 4'b0 || qwr !== 1'b0 || qa !== 32'h2001) begin
      n_bad++; $display("FAIL lb_req: strb=%b wr=%b addr=%h want 0000 0 00002001", qs, qwr, qa);
    end
  endtask

  task automatic test_load_half();
    int st, va; logic [31:0] qa, qw, qr; logic [3:0] qs; logic [1:0] qz; logic qwr; bit ok;
    xact(LHU, 32'h2002, 32'h0, 32'h8001ABCD, 1, 2, st, va, qa, qw, qr, qs, qz, qwr, ok);
    last_load = 32'h00008001;
    n_cmp++; if (!ok || st !== 5) begin n_bad++; $display("FAIL lhu_timing: done=%b stall=%0d want 1 5", ok, st); end
    n_cmp++; if (qr !== 32'h00008001 || va !== 1) begin n_bad++; $display("FAIL lhu_rdata: got %h/%0d want 00008001/1", qr, va); end
    n_cmp++; if (qz !== 2'd1) begin n_bad++; $display("FAIL lhu_size: got %0d want 1", qz); end
  endtask

  task automatic test_flush();
    int st, va; logic [31:0] qa, qw, qr; logic [3:0] qs; logic [1:0] qz; logic qwr; bit ok;
    @(negedge clk);
    en_i = 1; op_i = LB; addr_i = 32'h7000; flush_i = 0;
    @(negedge clk);
    flush_i = 1; en_i = 0;
    @(negedge clk);
    flush_i = 0;
    #1;
    n_cmp++; if (data_req !== 1'b0 || stall_o !== 1'b0) begin
      n_bad++; $display("FAIL flush_req: data_req=%b stall=%b want 0 0", data_req, stall_o);
    end
    @(negedge clk);
    en_i = 1; op_i = LW; addr_i = 32'h4000;
    @(negedge clk);
    data_addr_ok = 1;
    @(negedge clk);
    data_addr_ok = 0; flush_i = 1; en_i = 0;
    #1;
    n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL flush_wait_stall: got %b want 1", stall_o); end
    @(negedge clk);
    flush_i = 0;
    #1;
    n_cmp++; if (stall_o !== 1'b0 || data_req !== 1'b0) begin
      n_bad++; $display("FAIL flush_discard: stall=%b req=%b want 0 0", stall_o, data_req);
    end
    @(negedge clk);
    data_data_ok = 1; data_rdata = 32'hDEADBEEF;
    #1;
    va = int'(rdata_valid_o);
    @(negedge clk);
    data_data_ok = 0;
    #1;
    va += int'(rdata_valid_o);
    n_cmp++; if (va !== 0 || rdata_o !== last_load) begin
      n_bad++; $display("FAIL flush_drop: pulses=%0d rdata=%h want 0 %h", va, rdata_o, last_load);
    end
    xact(SW, 32'h5004, 32'h11223344, 32'h0, 1, 1, st, va, qa, qw, qr, qs, qz, qwr, ok);
    n_cmp++; if (!ok || st !== 4) begin n_bad++; $display("FAIL flush_sw_timing: done=%b stall=%0d want 1 4", ok, st); end
    n_cmp++; if (qa !== 32'h5004 || qw !== 32'h11223344 || qs !== 4'b1111 || qz !== 2'd2) begin
      n_bad++; $display("FAIL flush_sw_req: addr=%h wdata=%h strb=%b size=%0d want 00005004 11223344 1111 2", qa, qw, qs, qz);
    end
  endtask

  task automatic test_addr_align();
`ifdef MEM_ADDR_EXC_EN
    @(negedge clk);
    en_i = 1; op_i = LW; addr_i = 32'h3002;
    #1;
    n_cmp++; if (adel_o !== 1'b1 || ades_o !== 1'b0 || bad_addr_o !== 32'h3002 || stall_o !== 1'b0) begin
      n_bad++; $display("FAIL exc_lw: adel=%b ades=%b bad=%h stall=%b want 1 0 00003002 0", adel_o, ades_o, bad_addr_o, stall_o);
    end
    @(negedge clk);
    #1;
    n_cmp++; if (data_req !== 1'b0) begin n_bad++; $display("FAIL exc_lw_req: got %b want 0", data_req); end
    op_i = SH; addr_i = 32'h3001;
    #1;
    n_cmp++; if (ades_o !== 1'b1 || adel_o !== 1'b0 || bad_addr_o !== 32'h3001) begin
      n_bad++; $display("FAIL exc_sh: adel=%b ades=%b bad=%h want 0 1 00003001", adel_o, ades_o, bad_addr_o);
    end
    @(negedge clk);
    #1;
    n_cmp++; if (data_req !== 1'b0) begin n_bad++; $display("FAIL exc_sh_req: got %b want 0", data_req); end
    en_i = 0;
`else
    int st, va; logic [31:0] qa, qw, qr; logic [3:0] qs; logic [1:0] qz; logic qwr; bit ok;
    @(negedge clk);
    en_i = 1; op_i = LW; addr_i = 32'h3002;
    #1;
    n_cmp++; if (adel_o !== 1'b0 || bad_addr_o !== 32'h0) begin
      n_bad++; $display("FAIL noexc_flags: adel=%b bad=%h want 0 00000000", adel_o, bad_addr_o);
    end
    en_i = 0;
    xact(LW, 32'h3002, 32'h0, 32'hCAFEF00D, 0, 0, st, va, qa, qw, qr, qs, qz, qwr, ok);
    last_load = 32'hCAFEF00D;
    n_cmp++; if (qa !== 32'h3000 || qr !== 32'hCAFEF00D) begin
      n_bad++; $display("FAIL noexc_addr: addr=%h rdata=%h want 00003000 cafef00d", qa, qr);
    end
`endif
  endtask

  task automatic test_random();
    logic [5:0] ops [8] = '{LB, LBU, LH, LHU, LW, SB, SH, SW};
    logic [5:0] op;
    logic [31:0] addr, wd, rw, ea, qa, qw, qr, er;
    logic [35:0] es;
    logic [3:0] qs, xs;
    logic [1:0] qz;
    logic qwr;
    int n, al, dl, st, va;
    bit ok;
    for (int k = 0; k < 80; k++) begin
      op = ops[$urandom_range(0, 7)];
      n = nbytes(op);
      addr = $urandom; wd = $urandom; rw = $urandom;
      al = int'($urandom_range(0, 3)); dl = int'($urandom_range(0, 3));
`ifdef MEM_ADDR_EXC_EN
      addr = addr & ~(32'(n) - 32'd1);
`endif
      ea = addr & ~(32'(n) - 32'd1);
      es = exp_store(op, addr, wd);
      xs = is_st(op) ? es[35:32] : 4'b0000;
      xact(op, addr, wd, rw, al, dl, st, va, qa, qw, qr, qs, qz, qwr, ok);
      n_cmp++; if (!ok || st !== 2 + al + dl) begin
        n_bad++; $display("FAIL rnd_timing[%0d]: op=%h done=%b stall=%0d want 1 %0d", k, op, ok, st, 2 + al + dl);
      end
      n_cmp++; if (qa !== ea || qz !== 2'(n / 2) || qwr !== is_st(op) || qs !== xs) begin
        n_bad++; $display("FAIL rnd_req[%0d]: op=%h addr=%h size=%0d wr=%b strb=%b want %h %0d %b %b",
                          k, op, qa, qz, qwr, qs, ea, n / 2, is_st(op), xs);
      end
      if (is_st(op)) begin
        n_cmp++; if (qw !== es[31:0] || va !== 0) begin
          n_bad++; $display("FAIL rnd_store[%0d]: op=%h wdata=%h pulses=%0d want %h 0", k, op, qw, va, es[31:0]);
        end
      end else begin
        er = exp_load(op, addr, rw);
        last_load = er;
        n_cmp++; if (qr !== er || va !== 1) begin
          n_bad++; $display("FAIL rnd_load[%0d]: op=%h addr=%h word=%h got %h/%0d want %h/1", k, op, addr, rw, qr, va, er);
        end
      end
      n_cmp++; if (rdata_o !== last_load) begin
        n_bad++; $display("FAIL rnd_hold[%0d]: rdata=%h want %h", k, rdata_o, last_load);
      end
    end
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    en_i = 1; op_i = LH; addr_i = 32'h6000;
    @(negedge clk);
    #1;
    n_cmp++; if (data_req !== 1'b1) begin n_bad++; $display("FAIL rst_pre_req: got %b want 1", data_req); end
    rst = 1;
    #1;
    n_cmp++; if (data_req !== 1'b0 || stall_o !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_ctrl: req=%b stall=%b want 0 0", data_req, stall_o);
    end
    n_cmp++; if ({rdata_o, data_addr, data_wstrb, data_size, rdata_valid_o} !== '0) begin
      n_bad++; $display("FAIL rst_mid_data: rdata=%h addr=%h strb=%b size=%0d valid=%b want all 0",
                        rdata_o, data_addr, data_wstrb, data_size, rdata_valid_o);
    end
    @(negedge clk);
    rst = 0; en_i = 0;
    last_load = '0;
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_byte();
    test_load_half();
    test_flush();
    test_addr_align();
    test_random();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine; the counterpart of decode-stage immediate extension.
- Store direction: narrows register data into byte lanes and generates strobes.
- Load direction: selects the addressed byte or halfword from the returned word, then sign- or zero-extends it to 32 bits.
- Owns the request/response handshake to the SRAM-like data port and stalls the pipeline while a transfer is outstanding.

Parameters:
- ADDR_W, 32, data address width
- DATA_W, 32, data bus width (fixed at 32; checked by assertion)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- en_i  in  1  valid instruction in MEM stage
- op_i  in  6  primary opcode of the MEM-stage instruction
- addr_i  in  32  effective address
- wdata_i  in  32  rt value for stores
- flush_i  in  1  pipeline flush (exception/eret)
- stall_o  out  1  hold pipeline
- rdata_o  out  32  extended load result
- rdata_valid_o  out  1  rdata_o valid, one-cycle pulse
- adel_o  out  1  load address error
- ades_o  out  1  store address error
- bad_addr_o  out  32  faulting address
- data_req  out  1  request valid
- data_wr  out  1  1 = store
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  32  request address
- data_wdata  out  32  lane-replicated store data
- data_wstrb  out  4  byte strobes
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  response / write complete
- data_rdata  in  32  read word

Behaviour:
- Decoded ops: LB, LBU, LH, LHU, LW, SB, SH, SW. Any other op_i, or en_i=0, is not a memory op.
- Reset: FSM=IDLE; all outputs 0 (bad_addr_o=0, rdata_o=0).
- FSM states: IDLE, REQ, WAIT, DONE, DISCARD.
- IDLE: mem op && !flush_i && no address error → latch op, addr and wdata into request registers; go to REQ.
- stall_o is combinational: (IDLE && start) || REQ || WAIT || (DISCARD && en_i && mem op).
- REQ:
  - data_req=1; request registers held stable.
  - addr_ok=1 → WAIT.
  - addr_ok and data_ok both 1 in the same cycle → DONE directly.
  - flush_i && !addr_ok → drop data_req, go to IDLE.
- WAIT:
  - data_ok=1 → register the result, go to DONE.
  - flush_i → go to DISCARD.
- DONE:
  - rdata_valid_o=1 for loads only; stall_o=0.
  - Next state IDLE; the next request may start in the following cycle.
- DISCARD:
  - Wait for data_ok, drop the data, return to IDLE.
  - No rdata_valid_o pulse.
- Store lanes:
  - SB: wdata={4{wdata_i[7:0]}}, size 0, wstrb=4'b0001<<addr[1:0].
  - SH: {2{wdata_i[15:0]}}, size 1, wstrb=4'b0011<<{addr[1],1'b0}.
  - SW: wdata as-is, size 2, wstrb=4'b1111.
- Loads: data_wstrb=0.
- Load extraction:
  - Byte index = addr[1:0]; half index = addr[1].
  - LB/LH: sign-extend. LBU/LHU: zero-extend. LW: word passed through.
- rdata_o holds its value until the next load completes.
- Reset mid-transfer: immediate return to IDLE. The external port is assumed to be reset together with this unit.

Optional Feature:
- Macro: MEM_ADDR_EXC_EN.
- Defined:
  - LH/LHU with addr[0]≠0, or LW with addr[1:0]≠0 → adel_o=1.
  - SH/SW with the same misalignment → ades_o=1.
  - Both flags combinational in the en_i cycle; bad_addr_o=addr_i; no request issued; stall_o=0.
- Undefined:
  - adel_o/ades_o tied 0; bad_addr_o=0.
  - Halfword ops clear addr[0]; word ops clear addr[1:0].

Decomposition:
- Shared defines header, not this module:
  - opcode constants LB..SW;
  - size encodings SIZE_B/H/W;
  - FSM state encodings.
- One sub-module, mem_lane_align: purely combinational store-lane replication/strobe generation and load extraction. The parent holds the FSM and registers.

Test Plan:
- SB with addr=0x1003, wdata_i=0x000000A5, addr_ok one cycle later, data_ok the next cycle → data_wdata=0xA5A5A5A5, wstrb=1000, size=0; stall_o high 3 cycles.
- LB with addr=0x2001, data_rdata=0x1234F600 with addr_ok and data_ok in the same cycle → DONE next cycle; rdata_o=0xFFFFFFF6; rdata_valid_o pulses once.
- LHU with addr=0x2002, data_rdata=0x8001ABCD → rdata_o=0x00008001.
- LW issued, flush_i asserted in WAIT, data_ok 2 cycles later → no rdata_valid_o; FSM reaches IDLE; the next SW issues cleanly.
- MEM_ADDR_EXC_EN defined, LW at addr=0x3002 → adel_o=1, bad_addr_o=0x3002, data_req never asserted. Undefined build, same stimulus → data_addr=0x3000.
- rst asserted while in REQ → data_req and stall_o drop within the same cycle; all outputs 0.
